reset_sequencer: RTL and testbench

//   Clock-health reset sequencer for the core clock domain. Synchronises and

---
 rtl/reset_sequencer_if.sv | 30 +++
 rtl/reset_sequencer.sv | 137 +++++++++++++
 tb/tb_reset_sequencer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reset_sequencer_if.sv
// Control/status bundle of the reset sequencer: lock and software request in,
// per-domain resets and sequencer status out.
interface reset_sequencer_if #(
   parameter int CHANNELS = 3
) ();
   logic                pll_locked;
   logic                sw_reset_req;
   logic [CHANNELS-1:0] chan_resetn;
   logic                all_released;
   logic [7:0]          lock_lost_count;
   logic [1:0]          seq_state;

   modport master (
      input  pll_locked,
      input  sw_reset_req,
      output chan_resetn,
      output all_released,
      output lock_lost_count,
      output seq_state
   );

   modport slave (
      output pll_locked,
      output sw_reset_req,
      input  chan_resetn,
      input  all_released,
      input  lock_lost_count,
      input  seq_state
   );
endinterface

// File: rtl/reset_sequencer.sv
// Clock-health reset sequencer: filters PLL lock, then releases CHANNELS reset
// domains in index order after RELEASE_DELAY cycles, STAGGER cycles apart.
module reset_sequencer #(
   parameter int CHANNELS      = 3,
   parameter int LOCK_WINDOW   = 4,
   parameter int RELEASE_DELAY = 128,
   parameter int STAGGER       = 16
) (
   input logic               clk_core,
   input logic               resetn,
   reset_sequencer_if.master rs
);

   localparam int DW = $clog2(RELEASE_DELAY + 1);
   localparam int SW = $clog2(STAGGER + 1);
   localparam int CW = $clog2(CHANNELS + 1);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      DELAY     = 2'd1,
      RELEASE   = 2'd2,
      RUN       = 2'd3
   } seq_state_e;

   logic [1:0]             sync_q;
   logic [LOCK_WINDOW-1:0] window_q;
   logic                   lock_stable;

   seq_state_e             state_q;
   logic [DW-1:0]          delay_q;
   logic [SW-1:0]          stag_q;
   logic [CW-1:0]          chan_idx_q;
   logic [CHANNELS-1:0]    chan_q;
   logic                   all_q;
   logic [7:0]             lost_q;

   always_ff @(posedge clk_core or negedge resetn) begin
      if (!resetn) begin
         sync_q   <= '0;
         window_q <= '0;
      end else begin
         // NOTE: non-blocking so every flop samples its neighbour's pre-edge value.
         sync_q   <= {sync_q[0], rs.pll_locked};
         window_q <= (window_q << 1) | LOCK_WINDOW'(sync_q[1]);
      end
   end

   // Any single low sample in the window drops stability.
   assign lock_stable = &window_q;

   always_ff @(posedge clk_core or negedge resetn) begin
      if (!resetn) begin
         state_q    <= WAIT_LOCK;
         delay_q    <= '0;
         stag_q     <= '0;
         chan_idx_q <= '0;
         chan_q     <= '0;
         all_q      <= 1'b0;
         lost_q     <= '0;
      end else begin
         case (state_q)
            WAIT_LOCK: begin
               delay_q    <= '0;
               stag_q     <= '0;
               chan_idx_q <= '0;
               if (lock_stable) begin
                  state_q <= DELAY;
               end
            end

            DELAY, RELEASE, RUN: begin
               // Lock loss outranks a software request on the same edge.
               if (!lock_stable) begin
                  state_q    <= WAIT_LOCK;
                  delay_q    <= '0;
                  stag_q     <= '0;
                  chan_idx_q <= '0;
                  chan_q     <= '0;
                  all_q      <= 1'b0;
                  if (lost_q != 8'hFF) begin
                     lost_q <= lost_q + 8'd1;
                  end
               end else if (rs.sw_reset_req) begin
                  state_q    <= DELAY;
                  delay_q    <= '0;
                  stag_q     <= '0;
                  chan_idx_q <= '0;
                  chan_q     <= '0;
                  all_q      <= 1'b0;
               end else if (state_q == DELAY) begin
                  if (delay_q == DW'(RELEASE_DELAY - 1)) begin
                     delay_q    <= '0;
                     stag_q     <= '0;
                     chan_idx_q <= CW'(1);
                     chan_q     <= CHANNELS'(1);
                     if (CHANNELS == 1) begin
                        all_q   <= 1'b1;
                        state_q <= RUN;
                     end else begin
                        state_q <= RELEASE;
                     end
                  end else begin
                     delay_q <= delay_q + 1'b1;
                  end
               end else if (state_q == RELEASE) begin
                  if (stag_q == SW'(STAGGER - 1)) begin
                     stag_q     <= '0;
                     chan_idx_q <= chan_idx_q + 1'b1;
                     chan_q     <= (chan_q << 1) | CHANNELS'(1);
                     if (chan_idx_q == CW'(CHANNELS - 1)) begin
                        all_q   <= 1'b1;
                        state_q <= RUN;
                     end
                  end else begin
                     stag_q <= stag_q + 1'b1;
                  end
               end
            end

            default: state_q <= WAIT_LOCK;
         endcase
      end
   end

   assign rs.chan_resetn     = chan_q;
   assign rs.all_released    = all_q;
   assign rs.lock_lost_count = lost_q;
   assign rs.seq_state       = state_q;

   // Released domains always form a contiguous run from index 0.
   a_thermometer : assert property (@(posedge clk_core) disable iff (!resetn)
      (chan_q & (chan_q + CHANNELS'(1))) == '0);

   a_all_released : assert property (@(posedge clk_core) disable iff (!resetn)
      all_q == (&chan_q));

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: edge-count reference model feeding a scoreboard,
// plus directed checks of the key timing points and a reduced configuration.
module tb_reset_sequencer;

   localparam int CH = 3;
   localparam int LW = 4;
   localparam int RD = 128;
   localparam int ST = 16;

   typedef struct packed {
      logic [2:0] chan;
      logic       all;
      logic [1:0] state;
      logic [7:0] lost;
   } obs_t;

   logic clk_core;
   logic resetn;

   reset_sequencer_if #(.CHANNELS(CH)) sif ();
   reset_sequencer_if #(.CHANNELS(1))  sif2 ();

   reset_sequencer #(
      .CHANNELS(CH), .LOCK_WINDOW(LW), .RELEASE_DELAY(RD), .STAGGER(ST)
   ) dut (
      .clk_core(clk_core),
      .resetn  (resetn),
      .rs      (sif)
   );

   reset_sequencer #(
      .CHANNELS(1), .LOCK_WINDOW(1), .RELEASE_DELAY(1), .STAGGER(16)
   ) dut2 (
      .clk_core(clk_core),
      .resetn  (resetn),
      .rs      (sif2)
   );

   int   n_checks = 0;
   int   n_errors = 0;
   obs_t exp_q[$];

   initial begin
      clk_core = 1'b0;
      forever #5 clk_core = ~clk_core;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // Reference model: lock is stable when the LW samples taken 2..LW+1 edges
   // ago were all high; outputs follow from edges elapsed since DELAY entry.
   bit raw[$];

   function automatic bit stable_before(input int n);
      for (int k = n - 2 - LW; k <= n - 3; k++) begin
         if (k < 1) return 1'b0;
         if (!raw[k-1]) return 1'b0;
      end
      return 1'b1;
   endfunction

   initial begin
      int   edge_no;
      int   dly_start;
      int   lost_m;
      int   rel;
      int   e;
      bit   active;
      bit   ls;
      obs_t x;
      edge_no = 0; dly_start = 0; lost_m = 0; active = 1'b0;
      forever begin
         @(posedge clk_core);
         if (!resetn) begin
            edge_no = 0;
            raw.delete();
            active  = 1'b0;
            lost_m  = 0;
            x       = '0;
         end else begin
            edge_no++;
            ls = stable_before(edge_no);
            raw.push_back(sif.pll_locked);
            if (!active) begin
               if (ls) begin
                  active    = 1'b1;
                  dly_start = edge_no;
               end
            end else if (!ls) begin
               active = 1'b0;
               if (lost_m < 255) lost_m++;
            end else if (sif.sw_reset_req) begin
               dly_start = edge_no;
            end
            x = '0;
            x.lost = 8'(lost_m);
            if (active) begin
               e   = edge_no - dly_start;
               rel = (e < RD) ? 0 : 1 + (e - RD) / ST;
               if (rel > CH) rel = CH;
               x.chan  = 3'((1 << rel) - 1);
               x.all   = (rel == CH);
               x.state = (rel == 0) ? 2'd1 : (rel < CH) ? 2'd2 : 2'd3;
            end
         end
         exp_q.push_back(x);
      end
   end

   // Scoreboard monitor: compares each registered output set mid-cycle.
   initial begin
      obs_t want;
      obs_t got;
      forever begin
         @(negedge clk_core);
         if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = {sif.chan_resetn, sif.all_released, sif.seq_state, sif.lock_lost_count};
            check("scoreboard", 32'(got), 32'(want));
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "watchdog expired");
   end

   initial begin
      resetn            = 1'b0;
      sif.pll_locked    = 1'b1;
      sif.sw_reset_req  = 1'b0;
      sif2.pll_locked   = 1'b1;
      sif2.sw_reset_req = 1'b0;
      repeat (3) @(negedge clk_core);
      check("reset_chan", 32'(sif.chan_resetn), 0);
      check("reset_state", 32'(sif.seq_state), 0);
      check("reset_all", 32'(sif.all_released), 0);
      resetn = 1'b1;

      // Cold start timing for both configurations.
      repeat (4) @(posedge clk_core); #1;
      check("small_e4_chan", 32'(sif2.chan_resetn), 0);
      check("small_e4_state", 32'(sif2.seq_state), 1);
      @(posedge clk_core); #1;
      check("small_e5_chan", 32'(sif2.chan_resetn), 1);
      check("small_e5_all", 32'(sif2.all_released), 1);
      check("small_e5_state", 32'(sif2.seq_state), 3);
      @(posedge clk_core); #1;
      check("cold_e6_state", 32'(sif.seq_state), 0);
      @(posedge clk_core); #1;
      check("cold_e7_state", 32'(sif.seq_state), 1);
      repeat (127) @(posedge clk_core); #1;
      check("cold_e134_chan", 32'(sif.chan_resetn), 0);
      @(posedge clk_core); #1;
      check("cold_e135_chan", 32'(sif.chan_resetn), 1);
      check("cold_e135_state", 32'(sif.seq_state), 2);
      repeat (16) @(posedge clk_core); #1;
      check("cold_e151_chan", 32'(sif.chan_resetn), 3);
      repeat (15) @(posedge clk_core); #1;
      check("cold_e166_all", 32'(sif.all_released), 0);
      @(posedge clk_core); #1;
      check("cold_e167_chan", 32'(sif.chan_resetn), 7);
      check("cold_e167_all", 32'(sif.all_released), 1);
      check("cold_e167_state", 32'(sif.seq_state), 3);

      // One-cycle lock drop in RUN.
      @(negedge clk_core) sif.pll_locked = 1'b0;
      @(negedge clk_core) sif.pll_locked = 1'b1;
      repeat (3) @(posedge clk_core); #1;
      check("drop_chan", 32'(sif.chan_resetn), 0);
      check("drop_state", 32'(sif.seq_state), 0);
      check("drop_lost", 32'(sif.lock_lost_count), 1);
      repeat (200) @(negedge clk_core);

      // Software request in RUN.
      @(negedge clk_core) sif.sw_reset_req = 1'b1;
      @(negedge clk_core) sif.sw_reset_req = 1'b0;
      @(posedge clk_core); #1;
      check("sw_t1_state", 32'(sif.seq_state), 1);
      check("sw_t1_chan", 32'(sif.chan_resetn), 0);
      repeat (128) @(posedge clk_core); #1;
      check("sw_t129_chan", 32'(sif.chan_resetn), 1);
      repeat (32) @(posedge clk_core); #1;
      check("sw_t161_all", 32'(sif.all_released), 1);
      check("sw_lost", 32'(sif.lock_lost_count), 1);

      // Software request on the same edge as the lock loss.
      @(negedge clk_core) sif.pll_locked = 1'b0;
      @(negedge clk_core) sif.pll_locked = 1'b1;
      @(negedge clk_core);
      @(negedge clk_core) sif.sw_reset_req = 1'b1;
      @(negedge clk_core) sif.sw_reset_req = 1'b0;
      check("both_state", 32'(sif.seq_state), 0);
      check("both_lost", 32'(sif.lock_lost_count), 2);
      repeat (200) @(negedge clk_core);

      // Randomised lock segments with occasional software requests.
      for (int r = 0; r < 8; r++) begin
         int hold;
         int drop;
         hold = int'($urandom_range(0, 250));
         drop = int'($urandom_range(1, 3));
         for (int c = 0; c < hold; c++) begin
            @(negedge clk_core);
            sif.pll_locked   = 1'b1;
            sif.sw_reset_req = ($urandom_range(0, 99) == 0);
         end
         for (int c = 0; c < drop; c++) begin
            @(negedge clk_core);
            sif.pll_locked   = 1'b0;
            sif.sw_reset_req = 1'($urandom_range(0, 1));
         end
      end
      @(negedge clk_core);
      sif.pll_locked   = 1'b1;
      sif.sw_reset_req = 1'b0;
      repeat (20) @(negedge clk_core);

      // Asynchronous reset in the middle of RELEASE.
      @(negedge clk_core) sif.sw_reset_req = 1'b1;
      @(negedge clk_core) sif.sw_reset_req = 1'b0;
      repeat (140) @(negedge clk_core);
      check("pre_reset_state", 32'(sif.seq_state), 2);
      #2 resetn = 1'b0;
      #1;
      check("async_chan", 32'(sif.chan_resetn), 0);
      check("async_state", 32'(sif.seq_state), 0);
      check("async_lost", 32'(sif.lock_lost_count), 0);
      @(negedge clk_core) resetn = 1'b1;

      // Repeated lock losses until the counter saturates.
      repeat (12) @(negedge clk_core);
      for (int i = 0; i < 260; i++) begin
         sif.pll_locked = 1'b0;
         @(negedge clk_core) sif.pll_locked = 1'b1;
         repeat (int'($urandom_range(9, 14))) @(negedge clk_core);
      end
      repeat (12) @(negedge clk_core);
      check("saturated_lost", 32'(sif.lock_lost_count), 255);

      // Lock toggling every cycle never gets the small configuration past DELAY.
      for (int c = 0; c < 50; c++) begin
         @(negedge clk_core);
         if (c >= 6) begin
            check("toggle_state", 32'(sif2.seq_state[1]), 0);
            check("toggle_chan", 32'(sif2.chan_resetn), 0);
         end
         sif2.pll_locked = ~sif2.pll_locked;
      end

      repeat (5) @(negedge clk_core);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
